// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and the host.
// The master side is the receiver/host; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rd_en;
  logic                clear_overflow;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                empty;
  logic                full;
  logic [ADDR_WIDTH:0] count;
  logic                overflow;

  modport master (
    output rx_data, rx_valid, rd_en, clear_overflow,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  rx_data, rx_valid, rd_en, clear_overflow,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver. One byte is captured per
// rising edge of the receiver's data-ready level and held in a circular buffer
// until the host pops it with a registered read. Reports empty/full, occupancy
// and a sticky overflow flag for bytes that arrived while the buffer was full.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_rx_fifo_if.slave    bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage and state
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  rx_valid_q;
  logic [7:0]            rd_data_q;
  logic                  rd_valid_q;
  logic                  overflow_q;

  // Decoded per-cycle events
  logic empty_w;
  logic full_w;
  logic wr_req;
  logic rd_go;
  logic wr_go;
  logic drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // Decode write/read/drop events from the edge detector and occupancy
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_req = 1'b0;
    rd_go  = 1'b0;
    wr_go  = 1'b0;
    drop   = 1'b0;
    wr_req = bus.rx_valid & ~rx_valid_q;
    rd_go  = bus.rd_en & ~empty_w;
    // A read in the same cycle frees a slot, so a full buffer still accepts.
    wr_go  = wr_req & (~full_w | rd_go);
    drop   = wr_req & full_w & ~rd_go;
  end

  // Remember the previous data-ready level for rising-edge detection
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Start "high" so a level already asserted at release is not captured.
      rx_valid_q <= 1'b1;
    end else begin
      rx_valid_q <= bus.rx_valid;
    end
  end

  // Byte storage written at the write pointer
  // NOTE: the memory array has no reset; its contents are never observed
  // before being written, and a reset on it would forbid RAM inference.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  // Write pointer advances on every accepted byte, wrapping modulo DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (wr_go) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Registered read port: pop the oldest byte and flag it for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) begin
        // On a simultaneous write to the same slot this still returns the old
        // byte, since the memory update lands at the same edge.
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy tracks accepted writes minus reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      unique case ({wr_go, rd_go})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.overflow = overflow_q;

endmodule
